mux_scan_sampler: RTL

Parametrised N-input, W-bit channel selector with registered output and valid/ready handshake; successor to the lab's fixed 7-to-1 single-bit mux. Selects a channel either manually (switch-loaded select) or by an automatic round-robin scan with a programmable dwell time. Delivers each sample to a downstream consumer (display or LED driver) without dropping it. Sits between the board switch/input bank and the output stage in prelab top levels.

---
 rtl/mux_scan_pkg.sv | 12 +
 rtl/mux_scan_sampler_if.sv | 28 ++
 rtl/mux_scan_slot.sv | 54 +++++
 rtl/mux_scan_sampler.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/mux_scan_pkg.sv
// Shared types for the mux_scan_sampler block: scan FSM states and dwell counter width.
package mux_scan_pkg;

  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    MANUAL,
    SCAN,
    STALL
  } state_e;

endpackage

// File: rtl/mux_scan_sampler_if.sv
// Channel input bank, select controls and sample valid/ready output of mux_scan_sampler.
// master: the sampler side. slave: the board / consumer side.
interface mux_scan_sampler_if #(
  parameter int unsigned N_IN = 7,
  parameter int unsigned W    = 1
);
  localparam int unsigned SEL_W = $clog2(N_IN);

  logic [N_IN*W-1:0] in_data;
  logic              mode;
  logic [SEL_W-1:0]  sel_in;
  logic              sel_load;
  logic              out_ready;
  logic              out_valid;
  logic [W-1:0]      out_data;
  logic [SEL_W-1:0]  out_ch;
  logic              sel_err;

  modport master (
    input  in_data, mode, sel_in, sel_load, out_ready,
    output out_valid, out_data, out_ch, sel_err
  );

  modport slave (
    output in_data, mode, sel_in, sel_load, out_ready,
    input  out_valid, out_data, out_ch, sel_err
  );
endinterface

// File: rtl/mux_scan_slot.sv
// Output slot: holds one sample {data, ch} with valid until the consumer accepts it.
module mux_scan_slot #(
  parameter int unsigned W     = 1,
  parameter int unsigned SEL_W = 3
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load,
  input  logic [W-1:0]     load_data,
  input  logic [SEL_W-1:0] load_ch,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  output logic [SEL_W-1:0] out_ch,
  output logic             slot_free
);

  logic             valid_q, valid_d;
  logic [W-1:0]     data_q, data_d;
  logic [SEL_W-1:0] ch_q, ch_d;

  assign slot_free = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_ch    = ch_q;

  // New sample overwrites the slot (caller only loads when free); otherwise clear on acceptance.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ch_d    = ch_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
      ch_d    = load_ch;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  // Slot registers, dropped immediately on reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ch_q    <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
    end
  end

endmodule

// File: rtl/mux_scan_sampler.sv
// N-input, W-bit channel selector with manual load-and-sample or round-robin scan,
// feeding a valid/ready output slot without dropping dwell expiries.
// Optional macro MUX_SCAN_SELERR_EN: builds a sticky sel_err flag for out-of-range samples.
module mux_scan_sampler
  import mux_scan_pkg::*;
#(
  parameter int unsigned N_IN  = 7,
  parameter int unsigned W     = 1,
  parameter int unsigned DWELL = 4
) (
  input  logic             clk,
  input  logic             resetn,
  mux_scan_sampler_if.master bus
);

  localparam int unsigned       SEL_W    = $clog2(N_IN);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DWELL - 1);
  localparam logic [SEL_W-1:0]  SEL_LAST = SEL_W'(N_IN - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] cur_sel_q, cur_sel_d;
  logic [SEL_W-1:0] sel_next;
  logic             expired;
  logic             slot_free;
  logic             take;
  logic [SEL_W-1:0] take_sel;
  logic [W-1:0]     take_data;

  assign expired  = (cnt_q == CNT_LAST);
  assign sel_next = (cur_sel_q == SEL_LAST) ? '0 : cur_sel_q + SEL_W'(1);

  // State register: FSM state, dwell counter, current select.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= MANUAL;
      cnt_q     <= '0;
      cur_sel_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cur_sel_q <= cur_sel_d;
    end
  end

  // Next-state: mode drop beats sel_load, which beats dwell expiry; STALL parks cnt at DWELL-1.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cur_sel_d = cur_sel_q;
    unique case (state_q)
      MANUAL: begin
        if (bus.sel_load) cur_sel_d = bus.sel_in;
        if (bus.mode) begin
          state_d = SCAN;
          cnt_d   = '0;
        end
      end
      SCAN, STALL: begin
        if (!bus.mode) begin
          state_d = MANUAL;
          if (bus.sel_load) cur_sel_d = bus.sel_in;
        end else if (bus.sel_load) begin
          state_d   = SCAN;
          cur_sel_d = bus.sel_in;
          cnt_d     = '0;
        end else if (state_q == STALL || expired) begin
          if (slot_free) begin
            state_d   = SCAN;
            cur_sel_d = sel_next;
            cnt_d     = '0;
          end else begin
            state_d = STALL;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = MANUAL;
    endcase
  end

  // Output decode: when a sample is taken and which channel it uses.
  always_comb begin
    take     = 1'b0;
    take_sel = cur_sel_q;
    unique case (state_q)
      MANUAL: begin
        if (bus.sel_load && slot_free) begin
          take     = 1'b1;
          take_sel = bus.sel_in;
        end
      end
      SCAN, STALL: begin
        if (bus.mode && !bus.sel_load && (state_q == STALL || expired) && slot_free)
          take = 1'b1;
      end
      default: take = 1'b0;
    endcase
  end

  // Channel mux; select values beyond N_IN-1 match no channel and yield zero.
  always_comb begin
    take_data = '0;
    for (int unsigned k = 0; k < N_IN; k++) begin
      if (take_sel == SEL_W'(k)) take_data = bus.in_data[k*W +: W];
    end
  end

  mux_scan_slot #(
    .W     (W),
    .SEL_W (SEL_W)
  ) u_slot (
    .clk       (clk),
    .resetn    (resetn),
    .load      (take),
    .load_data (take_data),
    .load_ch   (take_sel),
    .out_ready (bus.out_ready),
    .out_valid (bus.out_valid),
    .out_data  (bus.out_data),
    .out_ch    (bus.out_ch),
    .slot_free (slot_free)
  );

`ifdef MUX_SCAN_SELERR_EN
  logic sel_err_q, sel_err_d;
  logic take_oor;

  assign take_oor = (32'(take_sel) >= 32'(N_IN));

  // Sticky flag: any sample with an out-of-range select sets it until reset.
  always_comb begin
    sel_err_d = sel_err_q | (take & take_oor);
  end

  // Flag register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) sel_err_q <= 1'b0;
    else         sel_err_q <= sel_err_d;
  end

  assign bus.sel_err = sel_err_q;
`else
  assign bus.sel_err = 1'b0;
`endif

endmodule
